fetch_buffer: RTL and testbench
===============================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of instruction FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_ADDR, default 32'h00000000, giving the first fetch address after reset.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 clock  input  1  rising-edge clock.
REQ-006 redirect_valid  input  1  restart fetch at redirect_addr.
REQ-007 redirect_addr  input  32  new fetch address, word aligned.
REQ-008 mem_valid  output  1  one-cycle fetch request to the instruction memory.
REQ-009 mem_instr  output  1  instruction-access flag, constant 1.
REQ-010 mem_addr  output  32  request address, meaningful only while mem_valid=1.
REQ-011 mem_rdata  input  32  response word, valid when mem_ready=1.
REQ-012 mem_ready  input  1  response strobe for the outstanding request.
REQ-013 out_valid  output  1  out_pc/out_instr hold a valid entry.
REQ-014 out_pc  output  32  address of the presented word.
REQ-015 out_instr  output  32  presented instruction word.
REQ-016 out_ready  input  1  consumer accepts the entry when out_valid=1 and out_ready=1 (pop).

Function
REQ-017 The block SHALL keep at most one memory request outstanding.
REQ-018 The block SHALL track the request with states IDLE (none outstanding), WAIT (outstanding, response kept) and DROP (outstanding, response discarded).
REQ-019 Transitions: IDLE->WAIT on issue; WAIT->IDLE on mem_ready without issue; WAIT->WAIT on mem_ready with issue; any outstanding state->DROP on redirect_valid without mem_ready; DROP->IDLE on mem_ready without issue; DROP->WAIT on mem_ready with issue.
REQ-020 Issue condition: redirect_valid=0, state IDLE or mem_ready=1, and count + (state==WAIT) - pop < DEPTH; mem_valid SHALL be combinational from this condition.
REQ-021 On issue mem_addr SHALL equal the fetch PC register, and the PC SHALL advance by 4 (mod 2^32, wrapping 32'hFFFFFFFC->0).
REQ-022 A response in WAIT SHALL be written to the FIFO as {PC of that request, mem_rdata}; a response in DROP SHALL be discarded.
REQ-023 On redirect_valid=1 the FIFO SHALL be flushed (count 0, out_valid 0 next cycle), the PC loaded with redirect_addr, no request issued that cycle, and any same-cycle response or pop ignored.
REQ-024 Simultaneous write and pop SHALL leave count unchanged; pop with out_valid=0 SHALL have no effect.
REQ-025 The FIFO SHALL never overflow; the issue rule of REQ-020 guarantees space for every WAIT response.
REQ-026 Without bypass, a written word SHALL appear on out_* the cycle after mem_ready, giving a 2-cycle request-to-output latency with a 1-cycle-latency memory and sustained throughput of one word per cycle.

Reset
REQ-027 While reset=1: state IDLE, count 0, PC=RESET_ADDR, out_valid=0, out_pc=0, out_instr=0, mem_valid=0, mem_addr=RESET_ADDR, mem_instr=1.
REQ-028 The first request SHALL issue in the first clock cycle after reset deasserts; a response arriving after a mid-operation reset SHALL be ignored (state IDLE).

Configuration
REQ-029 Macro FETCH_BUFFER_BYPASS_EN: when defined, a WAIT response arriving with the FIFO empty SHALL be presented on out_* combinationally that cycle and written only if not popped, giving 1-cycle latency; when undefined, REQ-026 applies and outputs are FIFO-registered only.

Verification
REQ-030 Reset release, 1-cycle-latency ROM, out_ready=1 -> mem_valid=1 addr 0x0 in cycle 0; out_valid=1 pc 0x0 instr 0x41014081 in cycle 2 (cycle 1 with BYPASS_EN); pc 0x4 instr 0x42014181 next cycle.
REQ-031 out_ready=0 held -> exactly DEPTH (4) requests issued, addresses 0x0..0xC, then mem_valid=0; raising out_ready drains entries in order and resumes issue at 0x10.
REQ-032 redirect_valid=1 addr 0x40 while WAIT -> response dropped, FIFO empty, next request addr 0x40, next out_pc 0x40 with instr 0x80678000.
REQ-033 redirect coincident with mem_ready and pop -> response and pop ignored, count 0, following request addr=redirect_addr.
REQ-034 Redirect to 0xFFFFFFFC -> requests 0xFFFFFFFC then 0x00000000.
REQ-035 reset asserted mid-WAIT with 3 entries -> out_valid=0 immediately, first post-reset request addr RESET_ADDR.

Source files
------------

// File: rtl/fetch_buffer_if.sv
// Bus bundle for fetch_buffer: instruction-memory request/response and the
// fetched-entry output stream. master = the fetch buffer, slave = its environment.
interface fetch_buffer_if;
   // Handshakes: a memory request is one cycle of mem_valid with mem_addr and is
   // answered by a later one-cycle mem_ready with mem_rdata; the output entry
   // moves only in a cycle where out_valid and out_ready are both high.
   logic        mem_valid;
   logic        mem_instr;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_ready;

   modport master (
      output mem_valid, mem_instr, mem_addr,
      input  mem_rdata, mem_ready,
      output out_valid, out_pc, out_instr,
      input  out_ready
   );

   modport slave (
      input  mem_valid, mem_instr, mem_addr,
      output mem_rdata, mem_ready,
      input  out_valid, out_pc, out_instr,
      output out_ready
   );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: one outstanding memory request, DEPTH-entry FIFO of {pc, instr}.
// Optional same-cycle bypass of a response into an empty FIFO: define FETCH_BUFFER_BYPASS_EN.
module fetch_buffer #(
   parameter int unsigned DEPTH      = 4,
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          redirect_valid,
   input  logic [31:0]   redirect_addr,
   fetch_buffer_if.master bus,
   output logic [1:0]    dbg_state
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   req_pc_q, req_pc_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [63:0]   ent_q [DEPTH];
   logic [63:0]   ent_d [DEPTH];

   logic          fifo_empty;
   logic          resp_keep;
   logic          bypass_hit;
   logic          pop;
   logic          fifo_pop;
   logic          wr_en;
   logic          issue;
   logic [CW:0]   room_need;

   always_comb begin
      fifo_empty = (count_q == '0);
      resp_keep  = (state_q == WAIT) && bus.mem_ready && !redirect_valid;
`ifdef FETCH_BUFFER_BYPASS_EN
      bypass_hit = resp_keep && fifo_empty;
`else
      bypass_hit = 1'b0;
`endif

      bus.out_valid = !fifo_empty || bypass_hit;
      bus.out_pc    = '0;
      bus.out_instr = '0;
      if (bypass_hit) begin
         bus.out_pc    = req_pc_q;
         bus.out_instr = bus.mem_rdata;
      end else if (!fifo_empty) begin
         bus.out_pc    = ent_q[rd_ptr_q][63:32];
         bus.out_instr = ent_q[rd_ptr_q][31:0];
      end

      pop      = bus.out_valid && bus.out_ready && !redirect_valid;
      fifo_pop = pop && !fifo_empty;
      wr_en    = resp_keep && !(bypass_hit && bus.out_ready);

      // Reserve a slot for the response still in flight so the FIFO cannot overflow.
      room_need = {1'b0, count_q} + {{CW{1'b0}}, (state_q == WAIT)} - {{CW{1'b0}}, pop};
      issue     = !reset && !redirect_valid &&
                  ((state_q == IDLE) || bus.mem_ready) &&
                  (room_need < (CW+1)'(DEPTH));

      bus.mem_valid = issue;
      bus.mem_instr = 1'b1;
      bus.mem_addr  = pc_q;
      dbg_state     = state_q;
   end

   always_comb begin
      state_d = state_q;
      if (redirect_valid) begin
         state_d = ((state_q != IDLE) && !bus.mem_ready) ? DROP : IDLE;
      end else begin
         case (state_q)
            IDLE:       if (issue) state_d = WAIT;
            WAIT, DROP: if (bus.mem_ready) state_d = issue ? WAIT : IDLE;
            default:    state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ent_d    = ent_q;
      if (redirect_valid) begin
         pc_d     = redirect_addr;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (issue) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
         end
         if (wr_en) begin
            ent_d[wr_ptr_q] = {req_pc_q, bus.mem_rdata};
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (fifo_pop) rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CW'(wr_en) - CW'(fifo_pop);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         pc_q     <= RESET_ADDR;
         req_pc_q <= RESET_ADDR;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ent_q    <= ent_d;
      end
   end
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: ROM responder with configurable latency,
// expected-entry queue for everything popped, cycle-exact checks on requests.
module tb_fetch_buffer;
`ifdef FETCH_BUFFER_BYPASS_EN
   localparam int FIRST_LAT = 1;
`else
   localparam int FIRST_LAT = 2;
`endif

   logic        clock;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_addr;
   logic [1:0]  dbg_state;

   fetch_buffer_if bus();

   fetch_buffer #(.DEPTH(4), .RESET_ADDR(32'h0)) dut (
      .clock          (clock),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .bus            (bus),
      .dbg_state      (dbg_state)
   );

   // clock / reset
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      reset = 1'b1;
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int          n_cmp = 0;
   int          n_err = 0;
   logic [63:0] exp_q[$];
   logic [31:0] req_log[$];
   logic        pend;
   logic [31:0] paddr;
   int          wcnt;
   int          mem_extra;
   int          first;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rom(input logic [31:0] a);
      if (a == 32'h40) return 32'h8067_8000;
      return 32'h4101_4081 + (a >> 2) * 32'h0100_0100;
   endfunction

   // One clock: capture the request of this cycle, then answer after the edge.
   task automatic tick();
      if (bus.mem_ready) pend = 1'b0;
      if (bus.mem_valid) begin
         pend  = 1'b1;
         paddr = bus.mem_addr;
         wcnt  = mem_extra;
         req_log.push_back(bus.mem_addr);
      end
      @(posedge clock);
      #1;
      if (pend && wcnt == 0) begin
         bus.mem_ready = 1'b1;
         bus.mem_rdata = rom(paddr);
      end else begin
         bus.mem_ready = 1'b0;
         bus.mem_rdata = '0;
         if (pend) wcnt--;
      end
      #1;
   endtask

   task automatic observe();
      logic [63:0] e;
      if (bus.out_valid && bus.out_ready && !redirect_valid) begin
         if (exp_q.size() == 0) begin
            check("extra_entry", 64'(exp_q.size()), 64'd1);
         end else begin
            e = exp_q.pop_front();
            check("pop_entry", {bus.out_pc, bus.out_instr}, e);
         end
      end
   endtask

   task automatic cyc();
      #1;
      observe();
      tick();
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         bus.out_ready = 1'b1;
         cyc();
         n++;
      end
      bus.out_ready = 1'b0;
      check("drain_left", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_addr  = '0;
      bus.out_ready  = 1'b0;
      bus.mem_ready  = 1'b0;
      bus.mem_rdata  = '0;
      pend           = 1'b0;
      wcnt           = 0;
      mem_extra      = 0;
      tick();
      tick();
      exp_q.delete();
      req_log.delete();
   endtask

   initial begin
      // reset values and first-fetch latency
      do_reset();
      #1;
      check("rst_mem_valid", bus.mem_valid, 1'b0);
      check("rst_mem_addr", bus.mem_addr, 32'h0);
      check("rst_mem_instr", bus.mem_instr, 1'b1);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_pc", bus.out_pc, 32'h0);
      check("rst_out_instr", bus.out_instr, 32'h0);
      check("rst_state", dbg_state, 2'd0);
      for (int i = 0; i < 8 - FIRST_LAT; i++)
         exp_q.push_back({32'(i * 4), rom(32'(i * 4))});
      bus.out_ready = 1'b1;
      reset = 1'b0;
      #1;
      check("a_c0_mem_valid", bus.mem_valid, 1'b1);
      check("a_c0_mem_addr", bus.mem_addr, 32'h0);
      first = -1;
      for (int c = 0; c < 8; c++) begin
         if (c == 1) check("a_c1_mem_addr", bus.mem_addr, 32'h4);
         if (bus.out_valid && first < 0) first = c;
         cyc();
      end
      check("a_first_out_cycle", 64'(first), 64'(FIRST_LAT));
      check("a_left", 64'(exp_q.size()), 64'd0);

      // back-pressure: exactly DEPTH requests, then ordered drain and resume
      do_reset();
      reset = 1'b0;
      for (int c = 0; c < 10; c++) cyc();
      #1;
      check("b_req_count", 64'(req_log.size()), 64'd4);
      for (int i = 0; i < 4; i++) check("b_req_addr", req_log[i], 32'(i * 4));
      check("b_stall_mem_valid", bus.mem_valid, 1'b0);
      check("b_full_out_valid", bus.out_valid, 1'b1);
      req_log.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back({32'(i * 4), rom(32'(i * 4))});
      bus.out_ready = 1'b1;
      for (int c = 0; c < 8; c++) cyc();
      bus.out_ready = 1'b0;
      check("b_resume_addr", req_log[0], 32'h10);
      check("b_left", 64'(exp_q.size()), 64'd0);

      // redirect while WAIT: late response dropped
      do_reset();
      bus.out_ready = 1'b1;
      mem_extra = 2;
      reset = 1'b0;
      cyc();
      redirect_valid = 1'b1;
      redirect_addr  = 32'h40;
      #1;
      check("c_redir_mem_valid", bus.mem_valid, 1'b0);
      check("c_redir_state", dbg_state, 2'd1);
      mem_extra = 0;
      cyc();
      redirect_valid = 1'b0;
      #1;
      check("c_drop_state", dbg_state, 2'd2);
      check("c_flush_out_valid", bus.out_valid, 1'b0);
      check("c_drop_mem_valid", bus.mem_valid, 1'b0);
      req_log.delete();
      exp_q.push_back({32'h40, 32'h8067_8000});
      exp_q.push_back({32'h44, rom(32'h44)});
      drain(12);
      check("c_first_req", req_log[0], 32'h40);

      // redirect coincident with response and pop
      do_reset();
      reset = 1'b0;
      cyc();
      cyc();
      redirect_valid = 1'b1;
      redirect_addr  = 32'h100;
      bus.out_ready  = 1'b1;
      #1;
      check("d_pre_out_valid", bus.out_valid, 1'b1);
      check("d_redir_mem_valid", bus.mem_valid, 1'b0);
      cyc();
      redirect_valid = 1'b0;
      bus.out_ready  = 1'b0;
      #1;
      check("d_out_valid", bus.out_valid, 1'b0);
      check("d_state", dbg_state, 2'd0);
      check("d_mem_valid", bus.mem_valid, 1'b1);
      check("d_mem_addr", bus.mem_addr, 32'h100);
      exp_q.push_back({32'h100, rom(32'h100)});
      drain(10);

      // PC wrap at the top of the address space
      do_reset();
      redirect_valid = 1'b1;
      redirect_addr  = 32'hFFFF_FFFC;
      reset = 1'b0;
      #1;
      check("e_redir_mem_valid", bus.mem_valid, 1'b0);
      cyc();
      redirect_valid = 1'b0;
      #1;
      check("e_mem_valid", bus.mem_valid, 1'b1);
      check("e_addr_top", bus.mem_addr, 32'hFFFF_FFFC);
      cyc();
      #1;
      check("e_addr_wrap", bus.mem_addr, 32'h0);
      exp_q.push_back({32'hFFFF_FFFC, rom(32'hFFFF_FFFC)});
      exp_q.push_back({32'h0, rom(32'h0)});
      drain(10);

      // reset mid-WAIT with three entries buffered
      do_reset();
      reset = 1'b0;
      cyc();
      cyc();
      cyc();
      mem_extra = 3;
      cyc();
      #1;
      check("f_pre_state", dbg_state, 2'd1);
      check("f_pre_out_valid", bus.out_valid, 1'b1);
      reset = 1'b1;
      pend  = 1'b0;
      #1;
      check("f_rst_out_valid", bus.out_valid, 1'b0);
      check("f_rst_out_pc", bus.out_pc, 32'h0);
      check("f_rst_mem_valid", bus.mem_valid, 1'b0);
      check("f_rst_state", dbg_state, 2'd0);
      mem_extra = 0;
      tick();
      reset = 1'b0;
      #1;
      check("f_first_mem_valid", bus.mem_valid, 1'b1);
      check("f_first_addr", bus.mem_addr, 32'h0);
      exp_q.push_back({32'h0, rom(32'h0)});
      exp_q.push_back({32'h4, rom(32'h4)});
      drain(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
